// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared limits, widths and sequencer states for the time-of-day clock
package clock_pkg;

  localparam int FIELD_W = 6;
  localparam int HR_W    = 5;

  localparam logic [FIELD_W-1:0] SEC_LIM = 6'd59;
  localparam logic [FIELD_W-1:0] MIN_LIM = 6'd59;
  localparam logic [FIELD_W-1:0] HR_LIM  = 6'd23;

  typedef enum logic [1:0] {
    IDLE,
    ADD_SEC,
    ADD_MIN,
    ADD_HR
  } state_t;

  // The field wraps when the incremented value reaches limit+1.
  function automatic logic field_wrap(input logic cout, input logic [FIELD_W-1:0] sum,
                                      input logic [FIELD_W-1:0] lim);
    return {cout, sum} == {1'b0, lim + FIELD_W'(1)};
  endfunction

endpackage

// File: rtl/add6.sv
// rtl/add6.sv - 6-bit ripple-carry adder made of per-bit full-adder cells
module add6
  import clock_pkg::*;
(
  input  logic [FIELD_W-1:0] a,
  input  logic [FIELD_W-1:0] b,
  input  logic               cin,
  output logic [FIELD_W-1:0] sum,
  output logic               cout
);

  logic [FIELD_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < FIELD_W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[FIELD_W];

endmodule

// File: rtl/time_update_ctrl.sv
// rtl/time_update_ctrl.sv - sequences one shared adder over sec/min/hr and arbitrates tick vs set buttons
module time_update_ctrl
  import clock_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sec_tick,
  input  logic               inc_min_req,
  input  logic               inc_hr_req,
  output logic [FIELD_W-1:0] sec,
  output logic [FIELD_W-1:0] min,
  output logic [HR_W-1:0]    hr,
  output logic               busy,
  output logic               day_wrap,
  output logic               tick_lost
);

  localparam logic [FIELD_W-1:0] ONE = FIELD_W'(1);

  state_t             state, state_d;
  logic               carry_mode, carry_d;
  logic               tick_pend, min_pend, hr_pend;
  logic               tick_req, min_req, hr_req;
  logic               serve_tick, serve_min, serve_hr;
  logic [FIELD_W-1:0] add_a, add_sum, field_lim, field_next;
  logic               add_cout, at_lim, day_wrap_d;

  // A live pulse in IDLE is treated as already pending.
  assign tick_req = tick_pend | sec_tick;
  assign min_req  = min_pend | inc_min_req;
  assign hr_req   = hr_pend | inc_hr_req;
  assign busy     = (state != IDLE);

  always_comb begin
    add_a     = '0;
    field_lim = SEC_LIM;
    case (state)
      ADD_SEC: begin add_a = sec;          field_lim = SEC_LIM; end
      ADD_MIN: begin add_a = min;          field_lim = MIN_LIM; end
      ADD_HR:  begin add_a = {1'b0, hr};   field_lim = HR_LIM;  end
      default: ;
    endcase
  end

  add6 u_add6 (
    .a    (add_a),
    .b    (ONE),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign at_lim     = field_wrap(add_cout, add_sum, field_lim);
  assign field_next = at_lim ? '0 : add_sum;

  always_comb begin
    state_d    = state;
    carry_d    = carry_mode;
    serve_tick = 1'b0;
    serve_min  = 1'b0;
    serve_hr   = 1'b0;
    day_wrap_d = 1'b0;
    case (state)
      IDLE: begin
        if (tick_req) begin
          state_d    = ADD_SEC;
          serve_tick = 1'b1;
        end else if (min_req) begin
          state_d   = ADD_MIN;
          carry_d   = 1'b0;
          serve_min = 1'b1;
        end else if (hr_req) begin
          state_d  = ADD_HR;
          carry_d  = 1'b0;
          serve_hr = 1'b1;
        end
      end
      ADD_SEC: begin
        if (at_lim) begin
          state_d = ADD_MIN;
          carry_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      // Set-mode minute wraps never ripple into hours.
      ADD_MIN: state_d = (at_lim && carry_mode) ? ADD_HR : IDLE;
      ADD_HR: begin
        state_d    = IDLE;
        day_wrap_d = at_lim & carry_mode;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      carry_mode <= 1'b0;
      tick_pend  <= 1'b0;
      min_pend   <= 1'b0;
      hr_pend    <= 1'b0;
      sec        <= '0;
      min        <= '0;
      hr         <= '0;
      day_wrap   <= 1'b0;
      tick_lost  <= 1'b0;
    end else begin
      state      <= state_d;
      carry_mode <= carry_d;
      day_wrap   <= day_wrap_d;
      tick_pend  <= (tick_pend | sec_tick) & ~serve_tick;
      min_pend   <= (min_pend | inc_min_req) & ~serve_min;
      hr_pend    <= (hr_pend | inc_hr_req) & ~serve_hr;
      tick_lost  <= tick_lost | (sec_tick & tick_pend);
      case (state)
        ADD_SEC: sec <= field_next;
        ADD_MIN: min <= field_next;
        ADD_HR:  hr  <= field_next[HR_W-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_time_update_ctrl.sv
// tb/tb_time_update_ctrl.sv - scoreboard bench for time_update_ctrl with directed vectors
module tb_time_update_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_tick = 1'b0;
  logic       inc_min_req = 1'b0;
  logic       inc_hr_req = 1'b0;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic       busy, day_wrap, tick_lost;

  time_update_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sec_tick    (sec_tick),
    .inc_min_req (inc_min_req),
    .inc_hr_req  (inc_hr_req),
    .sec         (sec),
    .min         (min),
    .hr          (hr),
    .busy        (busy),
    .day_wrap    (day_wrap),
    .tick_lost   (tick_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sec;
    int min;
    int hr;
    int len;
    int wraps;
    int lost;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   m_sec = 0, m_min = 0, m_hr = 0, m_lost = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int len, input int wraps);
    exp_t e;
    e.sec = m_sec; e.min = m_min; e.hr = m_hr;
    e.len = len; e.wraps = wraps; e.lost = m_lost;
    exp_q.push_back(e);
  endtask

  // Monitor: a service run ends when busy falls; compare against the oldest expectation.
  int   run_len = 0, run_wraps = 0;
  logic prev_busy = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0; run_wraps = 0; prev_busy = 1'b0;
    end else begin
      if (busy) begin
        run_len++;
        if (day_wrap) run_wraps++;
      end else if (prev_busy) begin
        if (day_wrap) run_wraps++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_run: got run of %0d cycles expected none", run_len);
        end else begin
          cur = exp_q.pop_front();
          chk("run_sec", int'(sec), cur.sec);
          chk("run_min", int'(min), cur.min);
          chk("run_hr", int'(hr), cur.hr);
          chk("run_busy_len", run_len, cur.len);
          chk("run_day_wrap", run_wraps, cur.wraps);
          chk("run_tick_lost", int'(tick_lost), cur.lost);
        end
        run_len = 0; run_wraps = 0;
      end else if (day_wrap) begin
        total++; bad++;
        $display("FAIL stray_day_wrap: got 1 expected 0");
      end
      prev_busy = busy;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_sec = 0; m_min = 0; m_hr = 0; m_lost = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sec"}, int'(sec), 0);
    chk({tag, "_min"}, int'(min), 0);
    chk({tag, "_hr"}, int'(hr), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_day_wrap"}, int'(day_wrap), 0);
    chk({tag, "_tick_lost"}, int'(tick_lost), 0);
  endtask

  task automatic settle();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    int len, wraps;
    len = 1; wraps = 0;
    if (m_sec == 59) begin
      m_sec = 0; len = 2;
      if (m_min == 59) begin
        m_min = 0; len = 3;
        if (m_hr == 23) begin m_hr = 0; wraps = 1; end
        else m_hr++;
      end else m_min++;
    end else m_sec++;
    push_exp(len, wraps);
    sec_tick = 1'b1;
    @(posedge clk);
    #1 sec_tick = 1'b0;
    settle();
  endtask

  task automatic do_min();
    m_min = (m_min == 59) ? 0 : m_min + 1;
    push_exp(1, 0);
    inc_min_req = 1'b1;
    @(posedge clk);
    #1 inc_min_req = 1'b0;
    settle();
  endtask

  task automatic do_hr();
    m_hr = (m_hr == 23) ? 0 : m_hr + 1;
    push_exp(1, 0);
    inc_hr_req = 1'b1;
    @(posedge clk);
    #1 inc_hr_req = 1'b0;
    settle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_zero("reset");

    // 00:00:58, then :59 (busy 1), then minute carry (busy 2)
    repeat (58) do_tick();
    do_tick();
    do_tick();

    // Reset while the minute carry step is in flight.
    repeat (59) do_tick();
    sec_tick = 1'b1;
    @(posedge clk);
    #1 sec_tick = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 chk_zero("mid_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_sec = 0; m_min = 0; m_hr = 0; m_lost = 0;

    // 23:59:59 -> 00:00:00 with day_wrap
    repeat (23) do_hr();
    repeat (59) do_min();
    repeat (59) do_tick();
    do_tick();

    // 05:59:30, minute button wraps without touching hours
    do_reset();
    repeat (5) do_hr();
    repeat (59) do_min();
    repeat (30) do_tick();
    do_min();

    // 23:10:00, hour button wraps with no day_wrap
    do_reset();
    repeat (23) do_hr();
    repeat (10) do_min();
    do_hr();

    // Tick and minute button together at 00:00:10
    do_reset();
    repeat (10) do_tick();
    m_sec = 11; push_exp(1, 0);
    m_min = 1;  push_exp(1, 0);
    sec_tick = 1'b1; inc_min_req = 1'b1;
    @(posedge clk);
    #1 sec_tick = 1'b0; inc_min_req = 1'b0;
    settle();

    // Ticks sampled in ADD_SEC and ADD_MIN: one is kept, one is lost.
    do_reset();
    repeat (59) do_tick();
    m_sec = 0; m_min = 1; m_lost = 1; push_exp(2, 0);
    m_sec = 1;                        push_exp(1, 0);
    sec_tick = 1'b1;
    repeat (3) @(posedge clk);
    #1 sec_tick = 1'b0;
    settle();
    settle();
    do_tick();

    settle();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
